mdu_ctrl: RTL
=============

# mdu_ctrl

- Iterative multiply/divide sequencer for the RV32M instructions.
- Accepts one M-extension operation from the execute stage and holds the pipeline via `stall_o` while it runs a 32-step shift-add multiply or restoring divide on operand magnitudes, with a sign-fixup step at the end.
- Returns the result as a one-cycle register write-back pulse, tagged with the destination address captured at accept.
- Sits beside `execute`; its write-back is muxed into the EX-MEM register by the integrating logic.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rstn_i` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: aborts any operation in flight and blocks acceptance this cycle.
- `start_i` input 1: operation request, sampled only in IDLE.
- `op_i` input 3: funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_i` input XLEN: multiplicand / dividend.
- `rs2_i` input XLEN: multiplier / divisor.
- `rd_addr_i` input 5: destination register.
- `stall_o` output 1: combinational hold request to the pipeline.
- `busy_o` output 1: registered; high in RUN and FIXUP.
- `rd_valid_o` output 1: one-cycle result strobe.
- `rd_addr_o` output 5: destination captured at accept.
- `rd_data_o` output XLEN: result; holds its value until the next completion.

## Operation
- FSM states: IDLE, RUN, FIXUP, DONE.
- IDLE -> RUN: on `start_i && !flush_i`.
  - Latch `op_i`, `rd_addr_i`, operand signs and operand magnitudes.
  - Clear the iteration counter (6-bit).
- IDLE -> DONE, special cases (no iteration):
  - Divide by zero, for ops 4-7.
  - Signed overflow: DIV/REM with `rs1_i`=0x80000000 and `rs2_i`=0xFFFFFFFF.
- RUN: one step per cycle for 32 cycles, then -> FIXUP.
  - Multiply step: 64-bit shift-add over magnitudes.
  - Divide step: restoring; shift one bit into the partial remainder, trial-subtract, set one quotient bit.
- FIXUP: apply sign, select the result word, register it into `rd_data_o`; -> DONE.
- DONE: `rd_valid_o` is high for this cycle; -> IDLE on the next edge.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
- Result sign rules:
  - Product is negated if the effective operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result word selection:
  - MUL: product[31:0].
  - MULH, MULHSU, MULHU: product[63:32].
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Special-case results:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = rs1.
  - Signed overflow: quotient 0x80000000; remainder 0.
- `start_i` outside IDLE is ignored. The pipeline keeps it asserted while stalled, so it re-presents the same instruction.
- `flush_i` in RUN or FIXUP: -> IDLE on the next edge, no result produced, `rd_data_o` unchanged.
- `flush_i` in DONE: `rd_valid_o` forced low combinationally; `rd_data_o` unchanged; -> IDLE.
- `stall_o` = (IDLE && `start_i` && !`flush_i`) || RUN || FIXUP.
  - Low in DONE, so execute advances in the same cycle the result is presented.
- Reset mid-operation:
  - Immediate return to IDLE.
  - All outputs go to their reset values asynchronously.
  - No stale `rd_valid_o` after reset release.

## Timing
- Reset values:
  - `busy_o`=0, `rd_valid_o`=0, `rd_addr_o`=0, `rd_data_o`=0.
  - `stall_o`=0 (while `start_i` is 0).
  - State IDLE.
- Normal latency: accept at edge E0; `rd_valid_o` high in the cycle after edge E33 (32 RUN + 1 FIXUP); state IDLE after E34.
- Special-case latency: `rd_valid_o` high in the cycle after E0.
- Back-to-back throughput: the next `start_i` can be accepted in the IDLE cycle following DONE. Worst case is one operation per 35 cycles.
- `busy_o` rises after E0 and falls after the edge that enters DONE.

## Test plan
- MUL 7 × 0xFFFFFFFD, rd=5:
  - `rd_data_o`=0xFFFFFFEB, `rd_addr_o`=5.
  - `rd_valid_o` exactly one cycle, in the cycle after E33.
  - `stall_o` high from the accept cycle through FIXUP.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- Divide and remainder, signed and unsigned:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- Special cases (single-cycle path, `busy_o` never rises):
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Flush:
  - `flush_i` at the 10th RUN cycle -> IDLE next edge, no `rd_valid_o`, `rd_data_o` unchanged.
  - A new MUL 3×4 then completes with 12.
  - `flush_i` during DONE -> `rd_valid_o` stays 0.
- Reset: assert `rstn_i` low asynchronously mid-RUN -> all outputs 0 immediately; after release, a DIVU 9/3 yields 3 with normal latency.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or
// restoring divide on operand magnitudes, followed by a sign-fixup step.
module mdu_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_addr_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            rd_valid_o,
   output logic [4:0]      rd_addr_o,
   output logic [XLEN-1:0] rd_data_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] ZERO      = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [5:0]      LAST_STEP = 6'(XLEN-1);

   function automatic logic rs1_signed(input logic [2:0] op);
      case (op)
         3'd0, 3'd1, 3'd2, 3'd4, 3'd6: rs1_signed = 1'b1;
         default:                      rs1_signed = 1'b0;
      endcase
   endfunction

   function automatic logic rs2_signed(input logic [2:0] op);
      case (op)
         3'd0, 3'd1, 3'd4, 3'd6: rs2_signed = 1'b1;
         default:                rs2_signed = 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
      magnitude = neg ? -v : v;
   endfunction

   state_t              state_r;
   state_t              state_s;
   logic [2:0]          op_r;
   logic [4:0]          rd_addr_r;
   logic                neg_res_r;
   logic                neg_rem_r;
   logic [5:0]          cnt_r;
   logic [XLEN-1:0]     opa_r;
   logic [2*XLEN-1:0]   acc_r;
   logic [XLEN-1:0]     rd_data_r;
   logic                busy_r;

   logic                sign1_s;
   logic                sign2_s;
   logic [XLEN-1:0]     mag1_s;
   logic [XLEN-1:0]     mag2_s;
   logic                div_zero_s;
   logic                div_ovf_s;
   logic                special_s;
   logic [XLEN-1:0]     special_res_s;
   logic                accept_s;
   logic                stall_s;
   logic [XLEN:0]       mul_sum_s;
   logic [2*XLEN-1:0]   mul_next_s;
   logic [XLEN:0]       div_shift_s;
   logic                div_ge_s;
   logic [XLEN-1:0]     div_diff_s;
   logic [2*XLEN-1:0]   div_next_s;
   logic [2*XLEN-1:0]   prod_s;
   logic [XLEN-1:0]     quo_s;
   logic [XLEN-1:0]     rem_s;
   logic [XLEN-1:0]     fix_res_s;

   // Operand decode at accept: effective signs, magnitudes and the no-iteration divide cases
   always_comb begin
      sign1_s       = rs1_signed(op_i) & rs1_i[XLEN-1];
      sign2_s       = rs2_signed(op_i) & rs2_i[XLEN-1];
      mag1_s        = magnitude(rs1_i, sign1_s);
      mag2_s        = magnitude(rs2_i, sign2_s);
      div_zero_s    = op_i[2] && (rs2_i == ZERO);
      div_ovf_s     = op_i[2] && !op_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
      special_s     = div_zero_s || div_ovf_s;
      special_res_s = ZERO;
      if (div_zero_s) begin
         special_res_s = op_i[1] ? rs1_i : ALL_ONES;
      end else if (div_ovf_s) begin
         special_res_s = op_i[1] ? ZERO : MIN_NEG;
      end else begin
         special_res_s = ZERO;
      end
   end

   // One iteration step; acc holds {hi,lo} for multiply and {remainder,quotient} for divide
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
      mul_next_s  = {mul_sum_s, acc_r[XLEN-1:1]};
      div_shift_s = acc_r[2*XLEN-1:XLEN-1];
      div_ge_s    = (div_shift_s >= {1'b0, opa_r});
      div_diff_s  = div_shift_s[XLEN-1:0] - opa_r;
      if (div_ge_s) begin
         div_next_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
         div_next_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
   end

   // Sign fixup and result word selection
   always_comb begin
      prod_s = neg_res_r ? -acc_r : acc_r;
      quo_s  = neg_res_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
      rem_s  = neg_rem_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
      case (op_r)
         3'd0:             fix_res_s = prod_s[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_res_s = prod_s[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_res_s = quo_s;
         3'd6, 3'd7:       fix_res_s = rem_s;
         default:          fix_res_s = ZERO;
      endcase
   end

   // Next-state logic and the pipeline hold request
   always_comb begin
      state_s  = state_r;
      stall_s  = 1'b0;
      accept_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               accept_s = 1'b1;
               stall_s  = 1'b1;
               state_s  = special_s ? S_DONE : S_RUN;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN: begin
            stall_s = 1'b1;
            if (flush_i) begin
               state_s = S_IDLE;
            end else if (cnt_r == LAST_STEP) begin
               state_s = S_FIXUP;
            end else begin
               state_s = S_RUN;
            end
         end
         S_FIXUP: begin
            stall_s = 1'b1;
            if (flush_i) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_DONE;
            end
         end
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // State and busy registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_r <= S_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == S_RUN) || (state_s == S_FIXUP);
      end
   end

   // Operand capture, iteration datapath and result register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         op_r      <= 3'd0;
         rd_addr_r <= 5'd0;
         neg_res_r <= 1'b0;
         neg_rem_r <= 1'b0;
         cnt_r     <= 6'd0;
         opa_r     <= ZERO;
         acc_r     <= {(2*XLEN){1'b0}};
         rd_data_r <= ZERO;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_r      <= op_i;
                  rd_addr_r <= rd_addr_i;
                  neg_res_r <= sign1_s ^ sign2_s;
                  neg_rem_r <= sign1_s;
                  cnt_r     <= 6'd0;
                  if (special_s) begin
                     rd_data_r <= special_res_s;
                  end else if (op_i[2]) begin
                     opa_r <= mag2_s;
                     acc_r <= {ZERO, mag1_s};
                  end else begin
                     opa_r <= mag1_s;
                     acc_r <= {ZERO, mag2_s};
                  end
               end
            end
            S_RUN: begin
               cnt_r <= cnt_r + 6'd1;
               acc_r <= op_r[2] ? div_next_s : mul_next_s;
            end
            S_FIXUP: begin
               if (!flush_i) begin
                  rd_data_r <= fix_res_s;
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign stall_o    = stall_s;
   assign busy_o     = busy_r;
   assign rd_valid_o = (state_r == S_DONE) && !flush_i;
   assign rd_addr_o  = rd_addr_r;
   assign rd_data_o  = rd_data_r;

endmodule
